// File: rtl/bch_decoder.sv
// BCH(15,7) t=2 decoder: bit-serial S1/S3 syndromes, direct locator solve, 15-step Chien search.
// state | meaning: IDLE wait start | SYND syndromes | SOLVE locator | CHIEN root search | FINISH publish
module bch_decoder (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [0:14] code,
    output logic [0:14] corrected,
    output logic [6:0]  msg_out,
    output logic [1:0]  err_count,
    output logic        uncorrectable,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE,
        SYND,
        SOLVE,
        CHIEN,
        FINISH
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [0:14] rx;
    logic [0:14] work;
    logic [3:0]  s1;
    logic [3:0]  s3;
    logic [3:0]  t1;
    logic [3:0]  t2;
    logic [3:0]  cnt;
    logic [3:0]  k;
    logic [1:0]  deg;
    logic [1:0]  roots;
    logic        fail;

    logic [3:0]  s1_cube;
    logic [3:0]  sigma1;
    logic [3:0]  sigma2;
    logic [1:0]  deg_solve;
    logic        fail_solve;
    logic        chien_root;

    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] x;
        p = 4'h0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[2:0], 1'b0} ^ (x[3] ? 4'b0011 : 4'b0000);
        end
        return p;
    endfunction

    function automatic logic [3:0] gf_inv(input logic [3:0] a);
        logic [3:0] r;
        case (a)
            4'h1:    r = 4'h1;
            4'h2:    r = 4'h9;
            4'h3:    r = 4'hE;
            4'h4:    r = 4'hD;
            4'h5:    r = 4'hB;
            4'h6:    r = 4'h7;
            4'h7:    r = 4'h6;
            4'h8:    r = 4'hF;
            4'h9:    r = 4'h2;
            4'hA:    r = 4'hC;
            4'hB:    r = 4'h5;
            4'hC:    r = 4'hA;
            4'hD:    r = 4'h4;
            4'hE:    r = 4'h3;
            4'hF:    r = 4'h8;
            default: r = 4'h0;
        endcase
        return r;
    endfunction

    // cnt counts down 14..0, so the bit index (degree 14-k) runs 0..14
    assign k          = 4'd14 - cnt;
    assign chien_root = ((4'h1 ^ t1 ^ t2) == 4'h0);
    assign msg_out    = corrected[0:6];

    always_comb begin
        s1_cube    = gf_mul(gf_mul(s1, s1), s1);
        sigma1     = 4'h0;
        sigma2     = 4'h0;
        deg_solve  = 2'd0;
        fail_solve = 1'b0;
        if (s1 == 4'h0) begin
            fail_solve = (s3 != 4'h0);
        end else if (s3 == s1_cube) begin
            deg_solve = 2'd1;
            sigma1    = s1;
        end else begin
            deg_solve = 2'd2;
            sigma1    = s1;
            sigma2    = gf_mul(s3, gf_inv(s1)) ^ gf_mul(s1, s1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SYND;
            SYND:    if (cnt == 4'd0) state_nxt = SOLVE;
            SOLVE:   state_nxt = fail_solve ? FINISH : CHIEN;
            CHIEN:   if (cnt == 4'd0) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx            <= '0;
            work          <= '0;
            s1            <= 4'h0;
            s3            <= 4'h0;
            t1            <= 4'h0;
            t2            <= 4'h0;
            cnt           <= 4'd0;
            deg           <= 2'd0;
            roots         <= 2'd0;
            fail          <= 1'b0;
            corrected     <= '0;
            err_count     <= 2'd0;
            uncorrectable <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        rx   <= code;
                        s1   <= 4'h0;
                        s3   <= 4'h0;
                        cnt  <= 4'd14;
                        busy <= 1'b1;
                    end
                end
                SYND: begin
                    s1  <= gf_mul(s1, 4'h2) ^ {3'b000, rx[k]};
                    s3  <= gf_mul(s3, 4'h8) ^ {3'b000, rx[k]};
                    cnt <= (cnt == 4'd0) ? 4'd14 : cnt - 4'd1;
                end
                SOLVE: begin
                    deg   <= deg_solve;
                    fail  <= fail_solve;
                    t1    <= gf_mul(sigma1, 4'h2);
                    t2    <= gf_mul(sigma2, 4'h4);
                    work  <= rx;
                    roots <= 2'd0;
                end
                CHIEN: begin
                    if (chien_root) begin
                        work[k] <= ~work[k];
                        roots   <= roots + 2'd1;
                    end
                    t1  <= gf_mul(t1, 4'h2);
                    t2  <= gf_mul(t2, 4'h4);
                    cnt <= (cnt == 4'd0) ? 4'd14 : cnt - 4'd1;
                end
                FINISH: begin
                    if (!fail && roots == deg) begin
                        corrected     <= work;
                        err_count     <= deg;
                        uncorrectable <= 1'b0;
                    end else begin
                        corrected     <= rx;
                        err_count     <= 2'd0;
                        uncorrectable <= 1'b1;
                    end
                    busy <= 1'b0;
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bch_decoder.sv
// Directed bench for bch_decoder: expected results queued at stimulus time, popped on done.
module tb_bch_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [0:14] code;
    logic [0:14] corrected;
    logic [6:0]  msg_out;
    logic [1:0]  err_count;
    logic        uncorrectable;
    logic        busy;
    logic        done;

    bch_decoder dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .code         (code),
        .corrected    (corrected),
        .msg_out      (msg_out),
        .err_count    (err_count),
        .uncorrectable(uncorrectable),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [0:14] word;
        logic [6:0]  msg;
        logic [1:0]  cnt;
        logic        unc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input logic [0:14] w, input logic [1:0] c, input logic u, input int lat);
        exp_t e;
        e.word = w;
        e.msg  = w[0:6];
        e.cnt  = c;
        e.unc  = u;
        e.lat  = lat;
        sb.push_back(e);
    endtask

    task automatic compare_out(input string tag, input int lat);
        exp_t e;
        if (sb.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s_scoreboard observed=done expected=no_output", tag);
            return;
        end
        e = sb.pop_front();
        check({tag, "_latency"}, 32'(lat), 32'(e.lat));
        check({tag, "_corrected"}, 32'(corrected), 32'(e.word));
        check({tag, "_msg"}, 32'(msg_out), 32'(e.msg));
        check({tag, "_errcnt"}, 32'(err_count), 32'(e.cnt));
        check({tag, "_uncorr"}, 32'(uncorrectable), 32'(e.unc));
        check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    endtask

    // one decode: start before E0, optional stray start pulse at edge glitch_at, code scrambled after E0
    task automatic run_decode(input string tag, input logic [0:14] w, input int glitch_at);
        int   e;
        logic seen;
        logic busy_low;
        code  = w;
        start = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        code     = ~w;
        e        = 0;
        seen     = 1'b0;
        busy_low = 1'b0;
        check({tag, "_busy_after_start"}, 32'(busy), 32'd1);
        while (e < 60 && !seen) begin
            if (glitch_at > 0 && e == glitch_at - 1) start = 1'b1;
            @(negedge clk);
            e++;
            if (e == glitch_at) start = 1'b0;
            if (done) seen = 1'b1;
            else if (!busy) busy_low = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            check({tag, "_busy_held"}, 32'(busy_low), 32'd0);
            compare_out(tag, e);
            @(negedge clk);
            check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        end
    endtask

    function automatic logic [14:0] encode(input logic [6:0] m);
        logic [14:0] r;
        logic [14:0] g;
        g = 15'h01D1;
        r = {m, 8'b0};
        for (int i = 14; i >= 8; i--)
            if (r[i]) r = r ^ (g << (i - 8));
        return {m, r[7:0]};
    endfunction

    initial begin
        int          nd;
        int          e;
        logic        extra;
        logic [6:0]  m;
        logic [14:0] cw;
        logic [14:0] rw;
        int          p1;
        int          p2;

        reset = 1'b1;
        start = 1'b0;
        code  = '0;
        repeat (3) @(negedge clk);
        check("rst_corrected", 32'(corrected), 32'd0);
        check("rst_msg", 32'(msg_out), 32'd0);
        check("rst_errcnt", 32'(err_count), 32'd0);
        check("rst_uncorr", 32'(uncorrectable), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        push_exp(15'h01D1, 2'd0, 1'b0, 32);
        run_decode("clean", 15'h01D1, 0);

        push_exp(15'h01D1, 2'd1, 1'b0, 32);
        run_decode("single", 15'h11D1, 0);

        // abort mid-SYND: outputs must drop to reset values and no done may follow
        code  = 15'h3FFE;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_corrected", 32'(corrected), 32'd0);
        check("abort_errcnt", 32'(err_count), 32'd0);
        check("abort_msg", 32'(msg_out), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        extra = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) extra = 1'b1;
        end
        check("abort_no_done", 32'(extra), 32'd0);

        push_exp(15'h7FFF, 2'd2, 1'b0, 32);
        run_decode("double", 15'h3FFE, 0);

        push_exp(15'h0013, 2'd0, 1'b1, 17);
        run_decode("uncorr", 15'h0013, 0);

        push_exp(15'h01D1, 2'd1, 1'b0, 32);
        run_decode("busy_start", 15'h01D5, 5);
        extra = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) extra = 1'b1;
        end
        check("busy_start_single_done", 32'(extra), 32'd0);

        // start held high: acceptances at E0, E33, E66
        for (int i = 0; i < 3; i++) push_exp(15'h0000, 2'd0, 1'b0, 32);
        code  = '0;
        start = 1'b1;
        @(negedge clk);
        e  = 0;
        nd = 0;
        while (e < 130) begin
            @(negedge clk);
            e++;
            if (e == 66) start = 1'b0;
            if (done) begin
                compare_out("stream", e - 33 * nd);
                nd++;
            end
        end
        check("stream_done_count", 32'(nd), 32'd3);

        for (int i = 0; i < 6; i++) begin
            m  = 7'($urandom_range(0, 127));
            cw = encode(m);
            p1 = int'($urandom_range(0, 14));
            p2 = (p1 + int'($urandom_range(1, 14))) % 15;
            rw = cw;
            if (i % 3 >= 1) rw[p1] = ~rw[p1];
            if (i % 3 == 2) rw[p2] = ~rw[p2];
            push_exp(cw, 2'(i % 3), 1'b0, 32);
            run_decode("random", rw, 0);
        end

        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
